// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared I2S definitions used by the tone engine transmitter and by the
// i2s_rx_capture receiver.
//   WS_LEFT / WS_RIGHT : word-select levels for the two channels
//   I2S_SAMPLE_WIDTH   : default number of bits kept per channel word
//   I2S_SYNC_STAGES    : default synchroniser depth for the I2S lines
// -----------------------------------------------------------------------------
package i2s_pkg;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    localparam int unsigned I2S_SAMPLE_WIDTH = 32'd16;
    localparam int unsigned I2S_SYNC_STAGES  = 32'd2;

    // Channel named by a word-select level.
    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

endpackage : i2s_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// N-stage synchroniser for one edge line plus a bundle of data lines, with a
// registered rising-edge strobe on the edge line.
//
// All lines go through the same number of flops, so their relative timing is
// preserved. One extra flop holds the previous synchronised value of every
// line; for the edge line it is the "previous" term of the edge detector, and
// for the data lines it keeps them aligned with the registered strobe. The
// data lines therefore use the synchroniser-only path.
//
// Ports
//   clk_in      : system clock
//   reset_n_in  : asynchronous active-low reset
//   edge_in     : asynchronous line whose rising edges are detected (bclk)
//   data_in     : asynchronous lines that are only synchronised (ws, d)
//   data_out    : data_in after synchronisation, aligned with rise_out
//   rise_out    : one-cycle pulse per rising edge of edge_in
// -----------------------------------------------------------------------------
module sync_edge_det
    import i2s_pkg::*;
#(
    parameter int unsigned STAGES = I2S_SYNC_STAGES,
    parameter int unsigned WIDTH  = 32'd2
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             edge_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             rise_out
);

    // Bit 0 of every stage carries the edge line, the upper bits the data.
    logic [STAGES-1:0][WIDTH:0] sync_q;
    logic [STAGES-1:0][WIDTH:0] sync_d;
    logic [WIDTH:0]             prev_q;
    logic [WIDTH:0]             prev_d;
    logic                       rise_q;
    logic                       rise_d;

    // Shift chain and edge detect: rise is "last stage high, previous low".
    always_comb begin
        sync_d[0] = {data_in, edge_in};
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1][0] & ~prev_q[0];
    end

    // Synchroniser, previous-value and strobe registers.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync_q <= '0;
            prev_q <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign data_out = prev_q[WIDTH:1];
    assign rise_out = rise_q;

endmodule : sync_edge_det

// File: rtl/i2s_rx_capture.sv
// -----------------------------------------------------------------------------
// i2s_rx_capture
// I2S slave receiver. Oversamples bclk/ws/data in the clk_in domain,
// deserialises left and right words MSB-first and presents one registered
// stereo pair per frame. Never drives any I2S line.
//
// Ports
//   clk_in          : system clock, at least 4x the bclk frequency
//   reset_n_in      : asynchronous active-low reset
//   i2s_bclk_in     : I2S bit clock from the transmitter
//   i2s_ws_in       : word select, 0 = left, 1 = right
//   i2s_d_in        : serial data, MSB first
//   left_out        : last completed left word
//   right_out       : last completed right word
//   frame_valid_out : one-cycle pulse when a full L+R pair has been updated
//   locked_out      : high once a WS transition has been seen since reset
//
// Pipeline (counted from the clk_in edge that first samples bclk high):
//   +SYNC_STAGES   : bit strobe with aligned ws/d out of sync_edge_det
//   +SYNC_STAGES+1 : framing stage folds the bit in, may raise a commit
//   +SYNC_STAGES+2 : output registers take the committed word
// -----------------------------------------------------------------------------
module i2s_rx_capture
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
    parameter int unsigned SYNC_STAGES  = I2S_SYNC_STAGES
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic                    i2s_bclk_in,
    input  logic                    i2s_ws_in,
    input  logic                    i2s_d_in,
    output logic [SAMPLE_WIDTH-1:0] left_out,
    output logic [SAMPLE_WIDTH-1:0] right_out,
    output logic                    frame_valid_out,
    output logic                    locked_out
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_WIDTH + 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [SAMPLE_WIDTH-1:0] MSB_MASK = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] line_sync_s;   // {d, ws} aligned with bclk_rise_s
    logic       bclk_rise_s;
    logic       ws_now_s;
    logic       d_now_s;

    sync_edge_det #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (32'd2)
    ) u_sync_bclk (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .edge_in    (i2s_bclk_in),
        .data_in    ({i2s_d_in, i2s_ws_in}),
        .data_out   (line_sync_s),
        .rise_out   (bclk_rise_s)
    );

    assign ws_now_s = line_sync_s[0];
    assign d_now_s  = line_sync_s[1];

    // ------------------------------------------------------------------
    // Framing / shift stage
    // ------------------------------------------------------------------
    logic [SAMPLE_WIDTH-1:0] shreg_q,    shreg_d;
    logic [CNT_W-1:0]        bit_cnt_q,  bit_cnt_d;
    logic                    ws_prev_q,  ws_prev_d;
    // ws_prev only means something after the first bit since reset;
    // without this the very first bit would look like a WS edge.
    logic                    ws_vld_q,   ws_vld_d;
    logic                    locked_q,   locked_d;
    logic                    cmt_stb_q,  cmt_stb_d;
    logic                    cmt_ch_q,   cmt_ch_d;
    logic [SAMPLE_WIDTH-1:0] cmt_word_q, cmt_word_d;

    logic [SAMPLE_WIDTH-1:0] bit_mask_s;
    logic [SAMPLE_WIDTH-1:0] fold_word_s;
    logic                    ws_change_s;

    // Fold the current bit into the shift register and detect word ends.
    always_comb begin
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        ws_prev_d  = ws_prev_q;
        ws_vld_d   = ws_vld_q;
        locked_d   = locked_q;
        cmt_stb_d  = 1'b0;
        cmt_ch_d   = cmt_ch_q;
        cmt_word_d = cmt_word_q;

        // Once bit_cnt reaches SAMPLE_WIDTH the mask shifts out to zero, so
        // extra bits of a long slot are dropped without a separate test.
        bit_mask_s  = MSB_MASK >> bit_cnt_q;
        fold_word_s = shreg_q | (bit_mask_s & {SAMPLE_WIDTH{d_now_s}});
        ws_change_s = ws_vld_q & (ws_now_s != ws_prev_q);

        if (bclk_rise_s) begin
            ws_prev_d = ws_now_s;
            ws_vld_d  = 1'b1;
            if (ws_change_s) begin
                // This bit is the LSB of the word for channel ws_prev.
                if (locked_q) begin
                    cmt_stb_d  = 1'b1;
                    cmt_ch_d   = ws_prev_q;
                    cmt_word_d = fold_word_s;
                end else begin
                    // First, partial word after reset is discarded.
                    cmt_stb_d  = 1'b0;
                end
                shreg_d   = '0;
                bit_cnt_d = '0;
                locked_d  = 1'b1;
            end else begin
                shreg_d = fold_word_s;
                if (bit_cnt_q < CNT_MAX) begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end else begin
                    bit_cnt_d = CNT_MAX;
                end
            end
        end else begin
            shreg_d   = shreg_q;
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Framing stage registers.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            ws_prev_q  <= WS_LEFT;
            ws_vld_q   <= 1'b0;
            locked_q   <= 1'b0;
            cmt_stb_q  <= 1'b0;
            cmt_ch_q   <= WS_LEFT;
            cmt_word_q <= '0;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            ws_prev_q  <= ws_prev_d;
            ws_vld_q   <= ws_vld_d;
            locked_q   <= locked_d;
            cmt_stb_q  <= cmt_stb_d;
            cmt_ch_q   <= cmt_ch_d;
            cmt_word_q <= cmt_word_d;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic [SAMPLE_WIDTH-1:0] left_q,      left_d;
    logic [SAMPLE_WIDTH-1:0] right_q,     right_d;
    logic                    frame_vld_q, frame_vld_d;
    logic                    left_seen_q, left_seen_d;

    // Route commits to the channel registers; a right commit that follows
    // a left commit closes the frame and fires the strobe.
    always_comb begin
        left_d      = left_q;
        right_d     = right_q;
        frame_vld_d = 1'b0;
        left_seen_d = left_seen_q;

        if (cmt_stb_q) begin
            if (cmt_ch_q == WS_LEFT) begin
                left_d      = cmt_word_q;
                left_seen_d = 1'b1;
            end else begin
                right_d = cmt_word_q;
                if (left_seen_q) begin
                    frame_vld_d = 1'b1;
                    left_seen_d = 1'b0;
                end else begin
                    frame_vld_d = 1'b0;
                end
            end
        end else begin
            frame_vld_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            left_q      <= '0;
            right_q     <= '0;
            frame_vld_q <= 1'b0;
            left_seen_q <= 1'b0;
        end else begin
            left_q      <= left_d;
            right_q     <= right_d;
            frame_vld_q <= frame_vld_d;
            left_seen_q <= left_seen_d;
        end
    end

    assign left_out        = left_q;
    assign right_out       = right_q;
    assign frame_valid_out = frame_vld_q;
    assign locked_out      = locked_q;

endmodule : i2s_rx_capture

// File: tb/tb_i2s_rx_capture.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_capture
// Self-checking bench for i2s_rx_capture. I2S frames are generated bit by bit
// with bclk = clk/8; the expected words come from the slot values by plain
// arithmetic (left-align into SAMPLE_WIDTH, truncate or zero-pad), and the
// expected pulse time from the clk cycle at which the right-word LSB's bclk
// rising edge is first sampled.
// -----------------------------------------------------------------------------
module tb_i2s_rx_capture;

    localparam int SW = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bclk;
    logic          ws;
    logic          d;
    logic [SW-1:0] left_out;
    logic [SW-1:0] right_out;
    logic          frame_valid_out;
    logic          locked_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int            pulse_cyc_q[$];
    logic [SW-1:0] pulse_l_q[$];
    logic [SW-1:0] pulse_r_q[$];
    int            exp_cyc_q[$];

    i2s_rx_capture #(
        .SAMPLE_WIDTH (SW),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk_in          (clk),
        .reset_n_in      (rst_n),
        .i2s_bclk_in     (bclk),
        .i2s_ws_in       (ws),
        .i2s_d_in        (d),
        .left_out        (left_out),
        .right_out       (right_out),
        .frame_valid_out (frame_valid_out),
        .locked_out      (locked_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle the strobe is high, with the words seen at that time.
    always @(negedge clk) begin
        if (frame_valid_out === 1'b1) begin
            pulse_cyc_q.push_back(cyc);
            pulse_l_q.push_back(left_out);
            pulse_r_q.push_back(right_out);
        end
    end

    // Expected word: the first SW bits of an n-bit MSB-first slot.
    function automatic logic [SW-1:0] exp_word(logic [31:0] val, int n);
        logic [31:0] v;
        v = (n >= 32) ? val : (val & ((32'd1 << n) - 32'd1));
        if (n >= SW) return SW'(v >> (n - SW));
        else         return SW'(v << (SW - n));
    endfunction

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        pulse_cyc_q.delete();
        pulse_l_q.delete();
        pulse_r_q.delete();
        exp_cyc_q.delete();
    endtask

    // One bclk period: 4 clk low (data changes), 4 clk high.
    task automatic send_bit(logic w, logic b, bit mark);
        @(negedge clk);
        bclk = 1'b0;
        ws   = w;
        d    = b;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        if (mark) exp_cyc_q.push_back(cyc + 1 + SS + 2);
        repeat (3) @(negedge clk);
    endtask

    // n-bit word for channel ch; its LSB already carries the next WS level.
    task automatic send_word(logic ch, logic [31:0] val, int n, logic nxt, bit mark);
        for (int i = 0; i < n; i++) begin
            send_bit((i == n - 1) ? nxt : ch, val[n-1-i], mark && (i == n - 1));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bclk = 1'b0; ws = 1'b0; d = 1'b0;
        idle(3);
        n_checks += 4;
        if (left_out !== 16'h0000)       begin n_fail++; $display("FAIL reset_left: got %h expected 0000", left_out); end
        if (right_out !== 16'h0000)      begin n_fail++; $display("FAIL reset_right: got %h expected 0000", right_out); end
        if (frame_valid_out !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b expected 0", frame_valid_out); end
        if (locked_out !== 1'b0)         begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked_out); end
        rst_n = 1'b1;
        idle(4);
        n_checks += 1;
        if (locked_out !== 1'b0)         begin n_fail++; $display("FAIL reset_release_locked: got %b expected 0", locked_out); end
    endtask

    task automatic test_partial_start();
        clear_q();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        idle(4);
        n_checks += 1;
        if (locked_out !== 1'b0) begin n_fail++; $display("FAIL partial_unlocked: got %b expected 0", locked_out); end
        send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        idle(4);
        n_checks += 2;
        if (locked_out !== 1'b1) begin n_fail++; $display("FAIL partial_locked: got %b expected 1", locked_out); end
        if (pulse_cyc_q.size() != 0) begin n_fail++; $display("FAIL partial_early_pulse: got %0d pulses expected 0", pulse_cyc_q.size()); end
        send_word(1'b0, 32'h00FF, 16, 1'b1, 1'b0);
        send_word(1'b1, 32'hFF00, 16, 1'b0, 1'b1);
        idle(10);
        n_checks += 1;
        if (pulse_cyc_q.size() != 1) begin
            n_fail++; $display("FAIL partial_pulses: got %0d expected 1", pulse_cyc_q.size());
        end else begin
            n_checks += 3;
            if (pulse_cyc_q[0] != exp_cyc_q[0]) begin n_fail++; $display("FAIL partial_latency: got cyc %0d expected %0d", pulse_cyc_q[0], exp_cyc_q[0]); end
            if (pulse_l_q[0] !== 16'h00FF)      begin n_fail++; $display("FAIL partial_left: got %h expected 00ff", pulse_l_q[0]); end
            if (pulse_r_q[0] !== 16'hFF00)      begin n_fail++; $display("FAIL partial_right: got %h expected ff00", pulse_r_q[0]); end
        end
    endtask

    // Sends one L/R frame and checks pulse count, exact latency and words.
    task automatic test_frame(string name, logic [31:0] lv, int ln, logic [31:0] rv, int rn);
        logic [SW-1:0] el, er;
        el = exp_word(lv, ln);
        er = exp_word(rv, rn);
        clear_q();
        send_word(1'b0, lv, ln, 1'b1, 1'b0);
        send_word(1'b1, rv, rn, 1'b0, 1'b1);
        idle(10);
        n_checks += 1;
        if (pulse_cyc_q.size() != 1) begin
            n_fail++; $display("FAIL %s_pulses: got %0d expected 1", name, pulse_cyc_q.size());
        end else begin
            n_checks += 3;
            if (pulse_cyc_q[0] != exp_cyc_q[0]) begin n_fail++; $display("FAIL %s_latency: got cyc %0d expected %0d", name, pulse_cyc_q[0], exp_cyc_q[0]); end
            if (pulse_l_q[0] !== el)            begin n_fail++; $display("FAIL %s_left: got %h expected %h", name, pulse_l_q[0], el); end
            if (pulse_r_q[0] !== er)            begin n_fail++; $display("FAIL %s_right: got %h expected %h", name, pulse_r_q[0], er); end
        end
        n_checks += 2;
        if (left_out !== el)  begin n_fail++; $display("FAIL %s_left_hold: got %h expected %h", name, left_out, el); end
        if (right_out !== er) begin n_fail++; $display("FAIL %s_right_hold: got %h expected %h", name, right_out, er); end
    endtask

    task automatic test_basic();
        test_frame("basic", 32'hA5C3, 16, 32'h1234, 16);
    endtask

    task automatic test_truncate();
        test_frame("trunc", 32'hBEEFFFFF, 32, 32'hCAFE0000, 32);
    endtask

    task automatic test_zero_pad();
        test_frame("pad", 32'h00AB, 8, 32'h00CD, 8);
    endtask

    task automatic test_mid_word_reset();
        clear_q();
        for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bclk  = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (left_out !== 16'h0000)    begin n_fail++; $display("FAIL mid_reset_left: got %h expected 0000", left_out); end
        if (right_out !== 16'h0000)   begin n_fail++; $display("FAIL mid_reset_right: got %h expected 0000", right_out); end
        if (frame_valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", frame_valid_out); end
        if (locked_out !== 1'b0)      begin n_fail++; $display("FAIL mid_reset_locked: got %b expected 0", locked_out); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Remainder of the interrupted left word, then a right word.
        send_word(1'b0, 32'h03FF, 10, 1'b1, 1'b0);
        send_word(1'b1, 32'h2222, 16, 1'b0, 1'b0);
        idle(10);
        n_checks += 4;
        if (pulse_cyc_q.size() != 0)  begin n_fail++; $display("FAIL mid_reset_no_pulse: got %0d pulses expected 0", pulse_cyc_q.size()); end
        if (locked_out !== 1'b1)      begin n_fail++; $display("FAIL mid_reset_relock: got %b expected 1", locked_out); end
        if (right_out !== 16'h2222)   begin n_fail++; $display("FAIL mid_reset_right_only: got %h expected 2222", right_out); end
        if (left_out !== 16'h0000)    begin n_fail++; $display("FAIL mid_reset_left_dropped: got %h expected 0000", left_out); end
        test_frame("after_reset", 32'h3C3C, 16, 32'hC3C3, 16);
    endtask

    task automatic test_back_to_back();
        logic [SW-1:0] el_q[$];
        logic [SW-1:0] er_q[$];
        logic [31:0]   lv, rv;
        int            ln, rn;
        clear_q();
        for (int f = 0; f < 12; f++) begin
            ln = $urandom_range(2, 32);
            rn = $urandom_range(2, 32);
            lv = $urandom;
            rv = $urandom;
            el_q.push_back(exp_word(lv, ln));
            er_q.push_back(exp_word(rv, rn));
            send_word(1'b0, lv, ln, 1'b1, 1'b0);
            send_word(1'b1, rv, rn, 1'b0, 1'b1);
        end
        idle(40);
        n_checks += 1;
        if (pulse_cyc_q.size() != 12) begin
            n_fail++; $display("FAIL b2b_pulses: got %0d expected 12", pulse_cyc_q.size());
        end else begin
            for (int f = 0; f < 12; f++) begin
                n_checks += 3;
                if (pulse_cyc_q[f] != exp_cyc_q[f]) begin n_fail++; $display("FAIL b2b_latency[%0d]: got cyc %0d expected %0d", f, pulse_cyc_q[f], exp_cyc_q[f]); end
                if (pulse_l_q[f] !== el_q[f])       begin n_fail++; $display("FAIL b2b_left[%0d]: got %h expected %h", f, pulse_l_q[f], el_q[f]); end
                if (pulse_r_q[f] !== er_q[f])       begin n_fail++; $display("FAIL b2b_right[%0d]: got %h expected %h", f, pulse_r_q[f], er_q[f]); end
            end
        end
        n_checks += 2;
        if (left_out !== el_q[11])  begin n_fail++; $display("FAIL b2b_left_hold: got %h expected %h", left_out, el_q[11]); end
        if (right_out !== er_q[11]) begin n_fail++; $display("FAIL b2b_right_hold: got %h expected %h", right_out, er_q[11]); end
    endtask

    initial begin
        test_reset();
        test_partial_start();
        test_basic();
        test_truncate();
        test_zero_pad();
        test_mid_word_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_i2s_rx_capture

// File: doc/i2s_rx_capture.md
Name: i2s_rx_capture

Overview:
- I2S slave receiver for the tone generator's I2S output (bclk/ws/data).
- Oversamples the three I2S lines in the system clock domain, deserialises the left and right words and presents one registered stereo pair per frame.
- Used as the loopback checker in the bench and as the capture front-end for the planned on-chip self-test path.
- Pure receiver: never drives any I2S line.

Parameters:
SAMPLE_WIDTH, 16, bits kept per channel word (MSB-first)
SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2)

Ports:
clk_in  input  1  system clock; must be at least 4x the bclk frequency
reset_n_in  input  1  asynchronous active-low reset
i2s_bclk_in  input  1  I2S bit clock from the transmitter
i2s_ws_in  input  1  word select: 0 = left, 1 = right
i2s_d_in  input  1  serial data, MSB first
left_out  output  SAMPLE_WIDTH  last completed left word
right_out  output  SAMPLE_WIDTH  last completed right word
frame_valid_out  output  1  one-clk_in pulse when a full L+R pair has been updated
locked_out  output  1  high once a WS transition has been seen since reset

Behaviour:
- Reset (asynchronous, reset_n_in low):
  - left_out = 0, right_out = 0, frame_valid_out = 0, locked_out = 0.
  - Synchronisers, shift register, bit counter and the left-captured flag are cleared.
  - Reset release is synchronous to clk_in.
- Input conditioning:
  - bclk, ws and d each pass through SYNC_STAGES flops. All three lines use the same delay, so their relative alignment is preserved.
  - One extra flop holds the previous synced bclk.
  - bclk_rise = synced bclk high AND previous low. It is a one-cycle strobe.
- Bit sampling:
  - On each bclk_rise cycle, sample synced ws (ws_now) and synced d. All updates below occur at that clock edge.
  - ws_prev holds ws_now from the previous bclk_rise.
- Word framing (standard I2S):
  - WS changes one bclk before the MSB.
  - At a bclk_rise where ws_now != ws_prev, the bit sampled on that edge is the LSB of the word for channel ws_prev. That word is complete at this edge.
- Per bclk_rise, without a WS change:
  - If bit_cnt < SAMPLE_WIDTH, shift d into shreg at position (SAMPLE_WIDTH-1-bit_cnt), i.e. MSB first.
  - Increment bit_cnt, saturating at SAMPLE_WIDTH.
  - Bits beyond SAMPLE_WIDTH are discarded (truncation of longer slots).
- Per bclk_rise, with a WS change (word end):
  - Fold the current bit in under the same rule as above.
  - If locked_out = 1: commit shreg to left_out (ws_prev = 0) or right_out (ws_prev = 1). Bit positions never filled stay 0, so short slots are zero-padded in the LSBs.
  - Then clear shreg and bit_cnt, and set locked_out = 1.
  - The first, partial word after reset is therefore discarded.
- Frame strobe:
  - A left commit sets the left_seen flag.
  - A right commit while left_seen = 1 asserts frame_valid_out for exactly one clk_in cycle and clears left_seen.
  - A right commit without a preceding left commit updates right_out but gives no pulse.
- Latency: frame_valid_out, left_out and right_out change exactly SYNC_STAGES+2 clk_in cycles after the clk_in edge at which i2s_bclk_in is first sampled high for the right-word LSB bit.
- No bclk activity: all outputs hold their values indefinitely. There is no timeout.
- Simultaneous WS change and reset: reset wins.
- Reset mid-word: the partial word is lost, and locked_out must re-acquire on the next WS edge.

Decomposition:
- Shared package i2s_pkg: WS_LEFT = 0 and WS_RIGHT = 1 constants, and the default SAMPLE_WIDTH. The tone engine's transmitter uses the same package.
- One sub-module, sync_edge_det: an N-stage synchroniser plus rising-edge strobe. It is instantiated for bclk; ws and d use its synchroniser-only path.
- The framing/shift logic stays in i2s_rx_capture.

Test Plan:
- 16-bit slots, bclk = clk/8: send left 0xA5C3 then right 0x1234. Expect left_out = 0xA5C3, right_out = 0x1234, one frame_valid_out pulse, latency checked exactly.
- Start mid-word after reset: send 5 right bits, then a full L = 0x00FF, R = 0xFF00. Expect the partial word dropped, locked_out rising on the first WS edge, a single pulse with 0x00FF / 0xFF00, and no earlier pulse.
- 32-bit slots, SAMPLE_WIDTH = 16: L = 0xBEEF + 16 bits of 0xFFFF, R = 0xCAFE + 0x0000. Expect left_out = 0xBEEF, right_out = 0xCAFE (truncation).
- 8-bit slots: L = 0xAB, R = 0xCD. Expect left_out = 0xAB00, right_out = 0xCD00 (zero-pad).
- Assert reset_n_in low for 3 cycles in the middle of a left word. Expect all outputs 0 immediately (asynchronous), no pulse for that frame, and correct capture of the next full frame.
- Loopback: tone engine I2S output into this block after an SPI tone setup. Expect a pulse every frame, left/right matching the engine's sample registers, and no pulse-count drift over 100 frames.
